// File: rtl/window_trap_ctrl_pkg.sv
// Shared constants for the window trap controller: FSM state encodings and
// the default hit-counter / threshold width.
package window_trap_ctrl_pkg;

  localparam int COUNT_W_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_TRAP  = 2'b10;

endpackage

// File: rtl/window_hit_counter.sv
// Saturating hit counter with synchronous clear/increment and a flag telling
// whether the next increment reaches the effective threshold.
module window_hit_counter
  import window_trap_ctrl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               clear,
  input  logic               inc,
  input  logic [COUNT_W-1:0] thresh,
  output logic [COUNT_W-1:0] count,
  output logic               reach
);

  logic [COUNT_W-1:0] teff;
  logic [COUNT_W:0]   count_plus1;

  // A zero threshold behaves as one so the first hit always traps.
  assign teff        = (thresh == '0) ? {{(COUNT_W-1){1'b0}}, 1'b1} : thresh;
  assign count_plus1 = {1'b0, count} + {{COUNT_W{1'b0}}, 1'b1};
  assign reach       = (count_plus1 >= {1'b0, teff});

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !count_plus1[COUNT_W]) begin
      count <= count_plus1[COUNT_W-1:0];
    end
  end

endmodule

// File: rtl/window_trap_ctrl.sv
// Counts qualified in-window accesses once armed and raises a held trap request
// at the programmed threshold. Build option: WINDOW_TRAP_AUTO_REARM_EN.
module window_trap_ctrl
  import window_trap_ctrl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [15:0]        DATA,
  input  logic               LD_THRESH,
  input  logic               ARM,
  input  logic               DISARM,
  input  logic               ADDR_VALID,
  input  logic               IN_WINDOW,
  input  logic               TRAP_ACK,
  output logic               TRAP_REQ,
  output logic               ARMED,
  output logic [COUNT_W-1:0] HIT_COUNT
);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [COUNT_W-1:0] thresh;
  logic               hit;
  logic               cnt_clear;
  logic               cnt_inc;
  logic               cnt_reach;

  assign hit = ADDR_VALID & IN_WINDOW;

  // Priority in ARMED: DISARM, then ARM restart, then hit counting.
  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ARM) begin
          state_nxt = ST_ARMED;
          cnt_clear = 1'b1;
        end
      end
      ST_ARMED: begin
        if (DISARM) begin
          state_nxt = ST_IDLE;
        end else if (ARM) begin
          cnt_clear = 1'b1;
        end else if (hit) begin
          cnt_inc = 1'b1;
          if (cnt_reach) begin
            state_nxt = ST_TRAP;
          end
        end
      end
      ST_TRAP: begin
        if (DISARM) begin
          state_nxt = ST_IDLE;
        end else if (TRAP_ACK) begin
`ifdef WINDOW_TRAP_AUTO_REARM_EN
          state_nxt = ST_ARMED;
          cnt_clear = 1'b1;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are flopped from the next-state decode so they never see inputs combinationally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      TRAP_REQ <= 1'b0;
      ARMED    <= 1'b0;
    end else begin
      state    <= state_nxt;
      TRAP_REQ <= (state_nxt == ST_TRAP);
      ARMED    <= (state_nxt == ST_ARMED);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      thresh <= '0;
    end else if (LD_THRESH) begin
      thresh <= DATA[COUNT_W-1:0];
    end
  end

  window_hit_counter #(
    .COUNT_W (COUNT_W)
  ) u_hit_counter (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .thresh (thresh),
    .count  (HIT_COUNT),
    .reach  (cnt_reach)
  );

endmodule

// File: tb/tb_window_trap_ctrl.sv
// Self-checking bench for window_trap_ctrl: directed scenarios then random
// traffic, all compared against a behavioural model of the trap rules.
module tb_window_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] DATA;
  logic        LD_THRESH;
  logic        ARM;
  logic        DISARM;
  logic        ADDR_VALID;
  logic        IN_WINDOW;
  logic        TRAP_ACK;
  logic        TRAP_REQ;
  logic        ARMED;
  logic [15:0] HIT_COUNT;

  int total = 0;
  int bad   = 0;

  // Reference model: plain flags and integers.
  bit m_armed;
  bit m_trap;
  int m_count;
  int m_thresh;

  window_trap_ctrl #(.COUNT_W(16)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DATA       (DATA),
    .LD_THRESH  (LD_THRESH),
    .ARM        (ARM),
    .DISARM     (DISARM),
    .ADDR_VALID (ADDR_VALID),
    .IN_WINDOW  (IN_WINDOW),
    .TRAP_ACK   (TRAP_ACK),
    .TRAP_REQ   (TRAP_REQ),
    .ARMED      (ARMED),
    .HIT_COUNT  (HIT_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic modelReset();
    m_armed  = 1'b0;
    m_trap   = 1'b0;
    m_count  = 0;
    m_thresh = 0;
  endtask

  // One rising edge worth of the trap rules, using the inputs held across the edge.
  task automatic modelStep();
    bit hit;
    int teff;
    hit  = ADDR_VALID && IN_WINDOW;
    teff = (m_thresh == 0) ? 1 : m_thresh;
    if (m_trap) begin
      if (DISARM) begin
        m_trap = 1'b0;
      end else if (TRAP_ACK) begin
        m_trap = 1'b0;
`ifdef WINDOW_TRAP_AUTO_REARM_EN
        m_armed = 1'b1;
        m_count = 0;
`endif
      end
    end else if (m_armed) begin
      if (DISARM) begin
        m_armed = 1'b0;
      end else if (ARM) begin
        m_count = 0;
      end else if (hit) begin
        if (m_count + 1 >= teff) begin
          m_armed = 1'b0;
          m_trap  = 1'b1;
        end
        if (m_count < 65535) m_count = m_count + 1;
      end
    end else if (ARM) begin
      m_armed = 1'b1;
      m_count = 0;
    end
    if (LD_THRESH) m_thresh = int'(DATA);
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (TRAP_REQ === m_trap) else begin
      bad++;
      $error("[TB] FAIL %s trap_req actual=%0b required=%0b", tag, TRAP_REQ, m_trap);
    end
    total++;
    assert (ARMED === m_armed) else begin
      bad++;
      $error("[TB] FAIL %s armed actual=%0b required=%0b", tag, ARMED, m_armed);
    end
    total++;
    assert (HIT_COUNT === m_count[15:0]) else begin
      bad++;
      $error("[TB] FAIL %s hit_count actual=%0d required=%0d", tag, HIT_COUNT, m_count);
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, then check away from the edge.
  task automatic applyStimulus(input string tag, input logic ld, input logic [15:0] data,
                               input logic arm, input logic disarm, input logic av,
                               input logic iw, input logic ack);
    LD_THRESH  = ld;
    DATA       = data;
    ARM        = arm;
    DISARM     = disarm;
    ADDR_VALID = av;
    IN_WINDOW  = iw;
    TRAP_ACK   = ack;
    @(posedge CLK);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic asyncReset(input string tag);
    #1;
    RESET = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    RESET      = 1'b1;
    DATA       = '0;
    LD_THRESH  = 1'b0;
    ARM        = 1'b0;
    DISARM     = 1'b0;
    ADDR_VALID = 1'b0;
    IN_WINDOW  = 1'b0;
    TRAP_ACK   = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_state");
    RESET = 1'b0;

    // Reset in the middle of counting, then a zeroed threshold traps on the first hit.
    applyStimulus("t1_ld5",   1, 16'd5, 0, 0, 0, 0, 0);
    applyStimulus("t1_arm",   0, 16'd0, 1, 0, 0, 0, 0);
    applyStimulus("t1_hit1",  0, 16'd0, 0, 0, 1, 1, 0);
    applyStimulus("t1_hit2",  0, 16'd0, 0, 0, 1, 1, 0);
    asyncReset("t1_async_reset");
    applyStimulus("t1_rearm", 0, 16'd0, 1, 0, 0, 0, 0);
    applyStimulus("t1_first", 0, 16'd0, 0, 0, 1, 1, 0);
    applyStimulus("t1_clr",   0, 16'd0, 0, 1, 0, 0, 0);

    // Address sweep against a 3..6 window with threshold 3.
    applyStimulus("t2_ld3", 1, 16'd3, 0, 0, 0, 0, 0);
    applyStimulus("t2_arm", 0, 16'd0, 1, 0, 0, 0, 0);
    for (int a = 0; a < 10; a++) begin
      applyStimulus($sformatf("t2_addr%0d", a), 0, 16'd0, 0, 0, 1, (a >= 3 && a <= 6), 0);
    end

    // Trap is held without an acknowledge, then released by one.
    for (int i = 0; i < 5; i++) begin
      applyStimulus("t3_hold", 0, 16'd0, 0, 0, 1, 1, 0);
    end
    applyStimulus("t3_ack",  0, 16'd0, 0, 0, 0, 0, 1);
    applyStimulus("t3_post", 0, 16'd0, 0, 1, 0, 0, 0);

    // Zero threshold and unqualified window flags.
    applyStimulus("t4_ld0",   1, 16'd0, 0, 0, 0, 0, 0);
    applyStimulus("t4_arm",   0, 16'd0, 1, 0, 0, 0, 0);
    applyStimulus("t4_noav",  0, 16'd0, 0, 0, 0, 1, 0);
    applyStimulus("t4_noav2", 0, 16'd0, 0, 0, 0, 1, 0);
    applyStimulus("t4_hit",   0, 16'd0, 0, 0, 1, 1, 0);
    applyStimulus("t4_dis",   0, 16'd0, 0, 1, 0, 0, 0);

    // DISARM beats ARM and a hit; IDLE ignores hits.
    applyStimulus("t5_ld10", 1, 16'd10, 0, 0, 0, 0, 0);
    applyStimulus("t5_arm",  0, 16'd0,  1, 0, 0, 0, 0);
    applyStimulus("t5_hit1", 0, 16'd0,  0, 0, 1, 1, 0);
    applyStimulus("t5_hit2", 0, 16'd0,  0, 0, 1, 1, 0);
    applyStimulus("t5_both", 0, 16'd0,  1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("t5_idle_hit", 0, 16'd0, 0, 0, 1, 1, 0);
    end

    // Threshold lowered below the current count while armed traps on the next hit.
    applyStimulus("t5b_arm",  0, 16'd0, 1, 0, 0, 0, 0);
    applyStimulus("t5b_hit",  0, 16'd0, 0, 0, 1, 1, 0);
    applyStimulus("t5b_hit",  0, 16'd0, 0, 0, 1, 1, 0);
    applyStimulus("t5b_ld1",  1, 16'd1, 0, 0, 0, 0, 0);
    applyStimulus("t5b_trap", 0, 16'd0, 0, 0, 1, 1, 0);
    applyStimulus("t5b_dis",  0, 16'd0, 0, 1, 0, 0, 0);

`ifdef WINDOW_TRAP_AUTO_REARM_EN
    // Continuous hits with every trap acknowledged.
    applyStimulus("t6_ld2", 1, 16'd2, 0, 0, 0, 0, 0);
    applyStimulus("t6_arm", 0, 16'd0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("t6_rearm", 0, 16'd0, 0, 0, 1, 1, m_trap);
    end
    applyStimulus("t6_dis", 0, 16'd0, 0, 1, 0, 0, 0);
`endif

    // Random traffic with small thresholds and occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset("rnd_reset");
      end
      applyStimulus("rnd",
                    ($urandom_range(0, 99) < 8),
                    16'($urandom_range(0, 6)),
                    ($urandom_range(0, 99) < 10),
                    ($urandom_range(0, 99) < 5),
                    ($urandom_range(0, 99) < 70),
                    ($urandom_range(0, 99) < 50),
                    ($urandom_range(0, 99) < 25));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
